// File: rtl/sequential_divider.sv
// sequential_divider: 8-bit restoring divider producing one quotient bit per clock.
// Latency: done 9 cycles after an accepted start (10 with DIVIDER_SIGNED_EN), 1 cycle for divisor==0.
// Backpressure: none; start is only sampled in IDLE, and requests while busy/done are dropped.
// Ports: clk, rst (sync, active-high), start/dividend/divisor in; quotient/remainder/div_by_zero
//        (held until the next completion), busy, done (1-cycle pulse) out.
// Optional macro DIVIDER_SIGNED_EN: two's-complement operands with a SIGN fix-up state.

module eight_bit_adder_substractor (
  input  logic [7:0] a,
  input  logic [7:0] b,
  input  logic       sign,       // 1 = subtract (a + ~b + 1)
  output logic [7:0] result,
  output logic       carry_out   // in subtract mode: 1 means no borrow (a >= b)
);
  logic [7:0] b_eff;
  assign b_eff = b ^ {8{sign}};
  assign {carry_out, result} = {1'b0, a} + {1'b0, b_eff} + {8'd0, sign};
endmodule

module sequential_divider (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] dividend,
  input  logic [7:0] divisor,
  output logic [7:0] quotient,
  output logic [7:0] remainder,
  output logic       busy,
  output logic       done,
  output logic       div_by_zero
);
  // SIGN is only reachable when DIVIDER_SIGNED_EN is defined.
  typedef enum logic [1:0] {IDLE, CALC, SIGN, DONE} state_t;

  state_t     state_q, state_d;
  logic [2:0] cnt_q, cnt_d;     // index of the dividend bit brought down next
  logic [7:0] p_q, p_d;         // partial remainder
  logic [7:0] n_q, n_d;         // latched dividend (magnitude in signed mode)
  logic [7:0] dvs_q, dvs_d;     // latched divisor (magnitude in signed mode)
  logic [7:0] qb_q, qb_d;       // quotient bits, shifted in MSB first
  logic [7:0] quot_q, quot_d;
  logic [7:0] rem_q, rem_d;
  logic       dbz_q, dbz_d;
`ifdef DIVIDER_SIGNED_EN
  logic       qneg_q, qneg_d;   // operand signs differ
  logic       rneg_q, rneg_d;   // dividend negative
`endif

  logic [7:0] sub_a, sub_res;
  logic       sub_cout, success;

  // Shift the next dividend bit into the partial remainder; the bit shifted out
  // (old P[7]) would make the 9-bit value at least 256, so it always succeeds.
  assign sub_a   = {p_q[6:0], n_q[cnt_q]};
  assign success = p_q[7] | sub_cout;

  eight_bit_adder_substractor u_sub (
    .a         (sub_a),
    .b         (dvs_q),
    .sign      (1'b1),
    .result    (sub_res),
    .carry_out (sub_cout)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    p_d     = p_q;
    n_d     = n_q;
    dvs_d   = dvs_q;
    qb_d    = qb_q;
    quot_d  = quot_q;
    rem_d   = rem_q;
    dbz_d   = dbz_q;
`ifdef DIVIDER_SIGNED_EN
    qneg_d  = qneg_q;
    rneg_d  = rneg_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
`ifdef DIVIDER_SIGNED_EN
          n_d    = dividend[7] ? -dividend : dividend;
          dvs_d  = divisor[7] ? -divisor : divisor;
          qneg_d = dividend[7] ^ divisor[7];
          rneg_d = dividend[7];
`else
          n_d    = dividend;
          dvs_d  = divisor;
`endif
          cnt_d  = 3'd7;
          p_d    = 8'h00;
          qb_d   = 8'h00;
          if (divisor == 8'h00) begin
            quot_d  = 8'hFF;
            rem_d   = dividend;
            dbz_d   = 1'b1;
            state_d = DONE;
          end else begin
            state_d = CALC;
          end
        end
      end
      CALC: begin
        // On success the 8-bit difference is exact since it is below the divisor.
        p_d   = success ? sub_res : sub_a;
        qb_d  = {qb_q[6:0], success};
        cnt_d = cnt_q - 3'd1;
        if (cnt_q == 3'd0) begin
`ifdef DIVIDER_SIGNED_EN
          state_d = SIGN;
`else
          quot_d  = {qb_q[6:0], success};
          rem_d   = success ? sub_res : sub_a;
          dbz_d   = 1'b0;
          state_d = DONE;
`endif
        end
      end
`ifdef DIVIDER_SIGNED_EN
      SIGN: begin
        // -128 / -1 wraps naturally: magnitude 128 is already 8'h80.
        quot_d  = qneg_q ? -qb_q : qb_q;
        rem_d   = rneg_q ? -p_q : p_q;
        dbz_d   = 1'b0;
        state_d = DONE;
      end
`endif
      DONE:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= 3'd0;
      p_q     <= 8'h00;
      n_q     <= 8'h00;
      dvs_q   <= 8'h00;
      qb_q    <= 8'h00;
      quot_q  <= 8'h00;
      rem_q   <= 8'h00;
      dbz_q   <= 1'b0;
`ifdef DIVIDER_SIGNED_EN
      qneg_q  <= 1'b0;
      rneg_q  <= 1'b0;
`endif
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      p_q     <= p_d;
      n_q     <= n_d;
      dvs_q   <= dvs_d;
      qb_q    <= qb_d;
      quot_q  <= quot_d;
      rem_q   <= rem_d;
      dbz_q   <= dbz_d;
`ifdef DIVIDER_SIGNED_EN
      qneg_q  <= qneg_d;
      rneg_q  <= rneg_d;
`endif
    end
  end

  assign quotient    = quot_q;
  assign remainder   = rem_q;
  assign div_by_zero = dbz_q;
  assign done        = (state_q == DONE);
  assign busy        = (state_q == CALC) || (state_q == SIGN);

endmodule

// File: tb/tb_sequential_divider.sv
module tb_sequential_divider;
  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic [7:0] dividend = 8'h00;
  logic [7:0] divisor = 8'h00;
  logic [7:0] quotient, remainder;
  logic       busy, done, div_by_zero;

`ifdef DIVIDER_SIGNED_EN
  localparam int LAT = 10;
`else
  localparam int LAT = 9;
`endif

  typedef struct {
    logic [7:0] q;
    logic [7:0] r;
    logic       dz;
    int         cyc;
    int         blen;
  } exp_t;

  exp_t exp_q[$];
  int   compared = 0;
  int   errs = 0;
  int   cyc = 0;
  int   busy_run = 0;

  sequential_divider dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .dividend    (dividend),
    .divisor     (divisor),
    .quotient    (quotient),
    .remainder   (remainder),
    .busy        (busy),
    .done        (done),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    compared++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Monitor: pops the scoreboard whenever the DUT signals done.
  always @(negedge clk) begin
    if (rst) begin
      busy_run = 0;
    end else begin
      if (busy) busy_run++;
      if (done) begin
        if (exp_q.size() == 0) begin
          compared++;
          errs++;
          $display("FAIL unexpected_done: got done=1 expected no done (cycle %0d)", cyc);
        end else begin
          exp_t e;
          e = exp_q.pop_front();
          chk("quotient", {24'd0, quotient}, {24'd0, e.q});
          chk("remainder", {24'd0, remainder}, {24'd0, e.r});
          chk("div_by_zero", {31'd0, div_by_zero}, {31'd0, e.dz});
          chk("done_cycle", cyc, e.cyc);
          chk("busy_length", busy_run, e.blen);
          chk("busy_in_done", {31'd0, busy}, 32'd0);
        end
        busy_run = 0;
      end
    end
  end

  // Issue one request; push the hand-computed result when it should complete.
  task automatic drive(input logic [7:0] a, input logic [7:0] b, input logic [7:0] eq,
                       input logic [7:0] er, input logic edz, input bit push);
    exp_t e;
    @(negedge clk);
    start    = 1'b1;
    dividend = a;
    divisor  = b;
    if (push) begin
      e.q    = eq;
      e.r    = er;
      e.dz   = edz;
      e.cyc  = cyc + ((b == 8'h00) ? 1 : LAT);
      e.blen = (b == 8'h00) ? 0 : LAT - 1;
      exp_q.push_back(e);
    end
    @(negedge clk);
    start    = 1'b0;
    dividend = 8'h5A;
    divisor  = 8'hC3;
  endtask

  task automatic wait_done();
    int n = 0;
    while (!done && n < 40) begin
      @(negedge clk);
      n++;
    end
    chk("done_within_budget", {31'd0, (n < 40)}, 32'd1);
  endtask

  task automatic chk_reset_outputs(input string tag);
    chk({tag, "_quotient"}, {24'd0, quotient}, 32'd0);
    chk({tag, "_remainder"}, {24'd0, remainder}, 32'd0);
    chk({tag, "_busy"}, {31'd0, busy}, 32'd0);
    chk({tag, "_done"}, {31'd0, done}, 32'd0);
    chk({tag, "_dbz"}, {31'd0, div_by_zero}, 32'd0);
  endtask

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_outputs("reset");
    // reset and start together: reset wins
    start = 1'b1; dividend = 8'd40; divisor = 8'd4;
    @(negedge clk);
    start = 1'b0;
    chk_reset_outputs("rst_with_start");
    rst = 1'b0;
    @(negedge clk);

`ifdef DIVIDER_SIGNED_EN
    drive(8'h9C, 8'h07, 8'hF2, 8'hFE, 1'b0, 1'b1);   // -100 / 7
    wait_done();
    drive(8'h80, 8'hFF, 8'h80, 8'h00, 1'b0, 1'b1);   // -128 / -1 wraps
    wait_done();
    drive(8'd100, 8'hF9, 8'hF2, 8'h02, 1'b0, 1'b1);  // 100 / -7
    wait_done();
    drive(8'd5, 8'd0, 8'hFF, 8'h05, 1'b1, 1'b1);
    wait_done();
    drive(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 1'b1);
`else
    drive(8'd200, 8'd7, 8'd28, 8'd4, 1'b0, 1'b1);
    wait_done();
    drive(8'd255, 8'd1, 8'd255, 8'd0, 1'b0, 1'b1);
    wait_done();
    drive(8'd13, 8'd200, 8'd0, 8'd13, 1'b0, 1'b1);   // back-to-back
    wait_done();
    drive(8'd255, 8'd128, 8'd1, 8'd127, 1'b0, 1'b1);
    wait_done();
    drive(8'd5, 8'd0, 8'hFF, 8'h05, 1'b1, 1'b1);
    wait_done();
    drive(8'd100, 8'd3, 8'd33, 8'd1, 1'b0, 1'b1);
`endif
    // stray start during the busy 100/3 must be dropped
    @(negedge clk);
    start = 1'b1; dividend = 8'd9; divisor = 8'd2;
    @(negedge clk);
    start = 1'b0;
    wait_done();
    repeat (4) @(negedge clk);
    chk("hold_quotient", {24'd0, quotient}, 32'd33);
    chk("hold_remainder", {24'd0, remainder}, 32'd1);
    chk("hold_done", {31'd0, done}, 32'd0);
    chk("hold_busy", {31'd0, busy}, 32'd0);

    // reset in flight: result discarded, no done
    drive(8'd77, 8'd3, 8'd0, 8'd0, 1'b0, 1'b0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk_reset_outputs("mid_reset");
    repeat (15) @(negedge clk);

    drive(8'd50, 8'd5, 8'd10, 8'd0, 1'b0, 1'b1);
    wait_done();
    repeat (3) @(negedge clk);
    chk("scoreboard_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, errs);
    $finish;
  end
endmodule

// File: doc/sequential_divider.md
# sequential_divider

Multi-cycle 8-bit restoring divider for the calculator datapath; the inverse of the multiplier path. Computes one quotient bit per clock by trial subtraction through a single `eight_bit_adder_substractor` instance in subtract mode (`sign`=1). Sits beside the multiplier behind the operation select and returns quotient, remainder and a divide-by-zero flag with a start/done handshake.

## Interface
- No parameters; widths fixed at 8 bits.
- `clk`  input  1  single clock, rising edge.
- `rst`  input  1  reset, synchronous, active-high.
- `start`  input  1  request; sampled only in IDLE.
- `dividend`  input  8  numerator; captured on accepted `start`.
- `divisor`  input  8  denominator; captured on accepted `start`.
- `quotient`  output  8  result; held until the next accepted `start`.
- `remainder`  output  8  result; held until the next accepted `start`.
- `busy`  output  1  high from the cycle after acceptance until `done`.
- `done`  output  1  one-cycle pulse; results are valid in this cycle.
- `div_by_zero`  output  1  set with `done` when `divisor`==0; held with results.

## Operation
- States: IDLE, CALC, DONE (plus SIGN when `DIVIDER_SIGNED_EN`).
- IDLE: `start`=1 latches operands. Divisor nonzero -> CALC with bit counter=7, partial remainder P=0. Divisor zero -> DONE directly.
- CALC, once per cycle: S = {P[7:0], Q[counter]} (9-bit, S[8]=old P[7]); trial = S[7:0] - D via the adder/subtractor; success = S[8] | carry_out. On success P=trial result and quotient bit=1; otherwise P=S[7:0] and quotient bit=0. Counter decrements; after counter 0 -> DONE.
- Arithmetic rule: the 8-bit trial result is exact on success, because the true difference is < D ≤ 255.
- DONE: `done`=1 for exactly one cycle, then IDLE. Final quotient/remainder registered on entry to DONE.
- Divide by zero: `quotient`=8'hFF, `remainder`=dividend, `div_by_zero`=1.
- `start` while not IDLE (including the DONE cycle) is ignored; no queuing.
- Operand inputs may change after acceptance without affecting the result.

## Timing
- Reset: state=IDLE; `quotient`, `remainder`=8'h00; `busy`, `done`, `div_by_zero`=0.
- `start` sampled at edge N (unsigned, divisor≠0): `busy` high cycles N+1..N+8; `done` and results in cycle N+9; `busy` low in the `done` cycle.
- Divisor zero: `done` in cycle N+1; `busy` never asserts.
- Next `start` accepted at earliest in the cycle after `done`.
- `rst` mid-operation: IDLE on the next edge, all outputs to reset values, the in-flight result is discarded and no `done` is produced.
- `rst` and `start` high together: reset wins.

## Configuration
- `DIVIDER_SIGNED_EN` defined: operands are two's complement. Magnitudes are divided unsigned, 8'h80 gives magnitude 128. A SIGN state between CALC and DONE negates the quotient if the operand signs differ, and gives the remainder the sign of the dividend. `done` moves to N+10 (zero divisor still N+1). Overflow -128 / -1 wraps to quotient 8'h80, remainder 0.
- Undefined: unsigned only, no SIGN state, timing as above.

## Test plan
- 200/7: `start` at edge N -> `done` at N+9, `quotient`=28, `remainder`=4, `div_by_zero`=0; `busy` high exactly 8 cycles.
- 255/1, then 13/200 back-to-back (second `start` the cycle after `done`) -> 255 r 0, then 0 r 13. Also 255/128 exercising the S[8] path -> 1 r 127.
- 5/0 -> `done` at N+1, `quotient`=8'hFF, `remainder`=8'h05, `div_by_zero`=1, `busy` stays 0.
- `start` pulsed with 9/2 at N+3 during a busy 100/3 -> ignored; only one `done`, with 33 r 1; outputs hold afterwards.
- `rst` at N+4 of a division -> outputs 0 next cycle, no `done`; fresh 50/5 then gives 10 r 0.
- With `DIVIDER_SIGNED_EN`: 8'h9C/8'h07 (-100/7) -> `done` at N+10, `quotient`=8'hF2, `remainder`=8'hFE; 8'h80/8'hFF -> 8'h80 r 0.
